kgd_ext: RTL

Parametrised successor to the KGD graphics controller: a Wishbone-slave bitmap display with 1/2/4 bits per pixel and an on-chip dual-port video RAM. Adds address auto-increment and a hardware fill engine. Scans pixels against the KSM col/row timing and drives a BPP-wide pixel output for the display mux. Everything runs in the single bus clock domain; col/row are synchronous to it.

---
 rtl/kgd_ext.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/kgd_ext.sv
// Wishbone bitmap display controller: 1/2/4 bpp video RAM with address
// auto-increment, a byte fill engine and a two-stage pixel scan pipeline.
module kgd_ext #(
  parameter int BPP    = 1,
  parameter int HPIX   = 400,
  parameter int VPIX   = 286,
  parameter int AW     = 14,
  parameter int HSTART = 40,
  parameter int VSTART = 51,
  parameter int HTOTAL = 1056,
  parameter int VTOTAL = 628
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [2:0]     wb_adr_i,
  input  logic [15:0]    wb_dat_i,
  output logic [15:0]    wb_dat_o,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  input  logic           wb_we_i,
  input  logic [1:0]     wb_sel_i,
  output logic           wb_ack_o,
  input  logic [10:0]    col,
  input  logic [9:0]     row,
  output logic [BPP-1:0] vgapix,
  output logic           genable,
  output logic           tdisable
);

  localparam int MEMBYTES = HPIX * VPIX * BPP / 8;
  localparam int LW       = AW + 4;
  localparam int BSH      = (BPP == 4) ? 2 : (BPP == 2) ? 1 : 0;
  localparam logic [10:0]   HS    = 11'(HSTART);
  localparam logic [10:0]   HE    = 11'(HSTART + 2 * HPIX);
  localparam logic [10:0]   HL    = 11'(HTOTAL - 1);
  localparam logic [9:0]    VS    = 10'(VSTART);
  localparam logic [9:0]    VE    = 10'(VSTART + 2 * VPIX);
  localparam logic [9:0]    VL    = 10'(VTOTAL - 1);
  localparam logic [AW-1:0] ALAST = AW'(MEMBYTES - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;
  state_t state_q, state_d;

  logic          reply, reply0, bus_strobe, bus_wr, bus_rd, busy;
  logic          fill_start, data_wr, ram_we;
  logic [1:0]    rs;
  logic          autoinc;
  logic [7:0]    pattern, ram_wd, ram_a_q, ram_b_q;
  logic [AW-1:0] areg;
  logic [15:0]   fcnt;
  logic          rd_vld_p1, rd_ram_p1;
  logic [15:0]   rd_reg_p1;
  logic [LW-1:0] lineadr, pix_p0;
  logic [LW+1:0] bit_p0;
  logic [10:0]   xoff;
  logic [AW-1:0] vaddr_p0;
  logic [2:0]    off_p0, off_p1;
  logic          vld_p0, vld_p1;
  logic [7:0]    mem [0:(1<<AW)-1];

  function automatic logic [AW-1:0] adr_inc(input logic [AW-1:0] a);
    return (a == ALAST) ? '0 : a + AW'(1);
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [15:0] d,
                                             input logic [1:0] sel);
    return {sel[1] ? d[15:8] : old[15:8], sel[0] ? d[7:0] : old[7:0]};
  endfunction

  function automatic logic [BPP-1:0] pix_sel(input logic [7:0] b, input logic [2:0] off);
    logic [7:0] s;
    s = b >> off;
    return s[BPP-1:0];
  endfunction

  assign rs         = wb_adr_i[2:1];
  assign bus_strobe = wb_cyc_i & wb_stb_i & ~(reply | reply0);
  assign bus_wr     = bus_strobe & wb_we_i;
  assign bus_rd     = bus_strobe & ~wb_we_i;
  assign busy       = (state_q == S_FILL);
  assign wb_ack_o   = reply0 & wb_stb_i;
  assign fill_start = bus_wr & (rs == 2'd0) & wb_sel_i[1] & wb_dat_i[12] & ~busy & (fcnt != 16'd0);
  assign data_wr    = bus_wr & (rs == 2'd1) & ~busy;
  // Fill owns port A while busy, so the bus path never collides with it.
  assign ram_we     = busy | (data_wr & wb_sel_i[0]);
  assign ram_wd     = busy ? pattern : wb_dat_i[7:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fill_start) state_d = S_FILL;
      S_FILL: if (fcnt == 16'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      reply    <= 1'b0;
      reply0   <= 1'b0;
      genable  <= 1'b0;
      tdisable <= 1'b0;
      autoinc  <= 1'b0;
      pattern  <= 8'h00;
      areg     <= '0;
      fcnt     <= 16'd0;
    end else begin
      reply  <= wb_stb_i;
      reply0 <= reply;
      if (bus_wr && rs == 2'd0) begin
        if (wb_sel_i[1]) {genable, tdisable, autoinc} <= wb_dat_i[15:13];
        if (wb_sel_i[0]) pattern <= wb_dat_i[7:0];
      end
      if (busy) begin
        areg <= adr_inc(areg);
        fcnt <= fcnt - 16'd1;
      end else if (bus_wr) begin
        case (rs)
          2'd1:    if (autoinc) areg <= adr_inc(areg);
          2'd2:    areg <= AW'(lane_merge(16'(areg), wb_dat_i, wb_sel_i));
          2'd3:    fcnt <= lane_merge(fcnt, wb_dat_i, wb_sel_i);
          default: ;
        endcase
      end else if (bus_rd && rs == 2'd1 && autoinc) begin
        areg <= adr_inc(areg);
      end
    end
  end

  // Read stage p1: register value captured at the strobe, RAM data lands here
  always_ff @(posedge wb_clk_i) begin
    if (bus_rd) begin
      rd_ram_p1 <= (rs == 2'd1) & ~busy;
      case (rs)
        2'd0:    rd_reg_p1 <= {genable, tdisable, autoinc, busy, 4'h0, pattern};
        2'd2:    rd_reg_p1 <= 16'(areg);
        2'd3:    rd_reg_p1 <= {row[4:0], col};
        default: rd_reg_p1 <= 16'h0000;
      endcase
    end
  end

  // Read stage p2: registered bus data, valid in the ack cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_vld_p1 <= 1'b0;
      wb_dat_o  <= 16'h0000;
    end else begin
      rd_vld_p1 <= bus_rd;
      if (rd_vld_p1) wb_dat_o <= rd_ram_p1 ? {8'h00, ram_a_q} : rd_reg_p1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (ram_we) mem[areg] <= ram_wd;
    ram_a_q <= mem[areg];
    ram_b_q <= mem[vaddr_p0];
  end

  // Video stage p0: window test and byte/bit address of the current pixel
  always_comb begin
    vld_p0   = (col >= HS) && (col < HE) && (row >= VS) && (row < VE);
    xoff     = col - HS;
    pix_p0   = lineadr + LW'(xoff[10:1]);
    bit_p0   = (LW+2)'(pix_p0) << BSH;
    vaddr_p0 = bit_p0[AW+2:3];
    off_p0   = bit_p0[2:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lineadr <= '0;
    end else if (col == HL) begin
      if (row == VL)
        lineadr <= '0;
      else if ((row >= VS) && (row < VE) && (row[0] ^ VS[0]))
        lineadr <= lineadr + LW'(HPIX);
    end
  end

  // Video stage p1: byte from port B plus its bit offset
  always_ff @(posedge wb_clk_i) off_p1 <= off_p0;

  // Video stage p2: pixel out, forced to 0 outside the window
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      vld_p1 <= 1'b0;
      vgapix <= '0;
    end else begin
      vld_p1 <= vld_p0;
      vgapix <= vld_p1 ? pix_sel(ram_b_q, off_p1) : '0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[0], xoff[0], bit_p0[LW+1:AW+3]};

endmodule
